// File: rtl/aes_mixw_pkg.sv
// Shared types and GF(2^8) helper for the AES MixColumns engine.
// Polynomial 0x11b; only the low byte is needed for xtime.
package aes_mixw_pkg;

  localparam logic [7:0] POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_e;

  typedef enum logic {
    MIX_FWD,
    MIX_INV
  } mode_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (POLY & {8{x[7]}});
  endfunction

endpackage

// File: rtl/aes_mixw_col.sv
// Single-column MixColumns / InvMixColumns, combinational.
// x2/x4/x8 per byte are shared by both directions.
module aes_mixw_col
  import aes_mixw_pkg::*;
(
  input  logic [31:0] col_i,
  input  mode_e       mode_i,
  output logic [31:0] col_o
);

  logic [7:0] b  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] rf [4];
  logic [7:0] ri [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]  = col_i[31-8*i -: 8];
      x2[i] = xtime(b[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  // Rows are cyclic shifts: fwd 2 3 1 1, inv 14 11 13 9.
  always_comb begin
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      rf[i] = x2[i]
            ^ x2[2'(i+1)] ^ b[2'(i+1)]
            ^ b[2'(i+2)]
            ^ b[2'(i+3)];
      ri[i] = (x8[i] ^ x4[i] ^ x2[i])
            ^ (x8[2'(i+1)] ^ x2[2'(i+1)] ^ b[2'(i+1)])
            ^ (x8[2'(i+2)] ^ x4[2'(i+2)] ^ b[2'(i+2)])
            ^ (x8[2'(i+3)] ^ b[2'(i+3)]);
      col_o[31-8*i -: 8] = (mode_i == MIX_INV) ? ri[i] : rf[i];
    end
  end

endmodule

// File: rtl/aes_mixw_seq.sv
// Sequential MixColumns engine; COLS_PER_CYCLE column units
// are time-multiplexed over the four state columns.
module aes_mixw_seq
  import aes_mixw_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         mode_i,
  input  logic [127:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] state_o
);

  localparam int CPC = COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(4 - CPC);
  localparam logic [1:0] STEP = 2'(CPC);

  if (CPC != 1 && CPC != 2 && CPC != 4) begin : g_bad_cpc
    $error("aes_mixw_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_e             fsm_q;
  mode_e            mode_q;
  logic [1:0]       cnt_q;
  // Element 0 is the MSB word, i.e. column 0.
  logic [0:3][31:0] st_q;

  logic [1:0]  idx   [CPC];
  logic [31:0] col_n [CPC];

  for (genvar g = 0; g < CPC; g++) begin : g_col
    assign idx[g] = cnt_q + 2'(g);
    aes_mixw_col u_col (
      .col_i  (st_q[idx[g]]),
      .mode_i (mode_q),
      .col_o  (col_n[g])
    );
  end

  assign in_ready_o  = (fsm_q == IDLE)
                     | ((fsm_q == DONE) & out_ready_i);
  assign out_valid_o = (fsm_q == DONE);
  assign state_o     = st_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fsm_q  <= IDLE;
      mode_q <= MIX_FWD;
      cnt_q  <= '0;
      st_q   <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q   <= state_i;
            mode_q <= mode_e'(mode_i);
            cnt_q  <= '0;
            fsm_q  <= BUSY;
          end
        end
        BUSY: begin
          for (int g = 0; g < CPC; g++) begin
            st_q[idx[g]] <= col_n[g];
          end
          cnt_q <= cnt_q + STEP;
          if (cnt_q == LAST) fsm_q <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            if (in_valid_i) begin
              st_q   <= state_i;
              mode_q <= mode_e'(mode_i);
              cnt_q  <= '0;
              fsm_q  <= BUSY;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mixw_seq.sv
// Bench for aes_mixw_seq: one instance per legal COLS_PER_CYCLE,
// checked against a GF(2^8) matrix-multiply reference model.
module tb_aes_mixw_seq;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         mode_in   [3];
  logic [127:0] st_in     [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] st_out    [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixw_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .nreset      (nreset),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .mode_i      (mode_in[g]),
      .state_i     (st_in[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .state_o     (st_out[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--)
      if (p[i]) p ^= 16'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s,
                                         input logic inv);
    logic [7:0] fm [4] = '{8'h2, 8'h3, 8'h1, 8'h1};
    logic [7:0] im [4] = '{8'he, 8'hb, 8'hd, 8'h9};
    logic [7:0] a [16];
    logic [7:0] r;
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) a[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        r = '0;
        for (int j = 0; j < 4; j++)
          r ^= gmul(inv ? im[(j-row+4)%4] : fm[(j-row+4)%4],
                    a[4*c+j]);
        o[127-32*c-8*row -: 8] = r;
      end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lat(input int u);
    return 4 >> u;
  endfunction

  // One block: handshake, wait for result, check latency/data, consume.
  task automatic run_block(input int u, input logic [127:0] s,
                           input logic m, input bit scramble,
                           input logic [127:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    out_ready[u] = 1'b1;
    in_valid[u] = 1'b1;
    st_in[u] = s;
    mode_in[u] = m;
    chk({tag, "_rdy"}, 128'(in_ready[u]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    while (!out_valid[u] && n < 16) begin
      if (scramble) begin
        in_valid[u] = 1'b1;
        st_in[u] = rnd128();
        mode_in[u] = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid[u] = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(lat(u)));
    chk({tag, "_data"}, st_out[u], exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drain"}, 128'(out_valid[u]), 128'd0);
  endtask

  // Back-to-back forward/inverse pairs with out_ready tied high.
  task automatic stream(input int u, input int nblk);
    logic [127:0] orig, expv;
    logic m;
    int n, bad_p = 0, bad_d = 0;
    @(negedge clk);
    out_ready[u] = 1'b1;
    orig = rnd128();
    m = 1'b0;
    expv = model(orig, 1'b0);
    in_valid[u] = 1'b1;
    st_in[u] = orig;
    mode_in[u] = m;
    @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < nblk; b++) begin
      in_valid[u] = 1'b0;
      n = 0;
      while (!out_valid[u] && n < 16) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      if (n + 1 != lat(u) + 1 || bad_p == 0)
        chk("rt_period", 128'(n + 1), 128'(lat(u) + 1));
      if (st_out[u] !== expv || bad_d == 0)
        chk("rt_data", st_out[u], expv);
      bad_p = 1;
      bad_d = 1;
      if (b != nblk - 1) begin
        if (m == 1'b0) begin
          st_in[u] = expv;
          m = 1'b1;
          expv = orig;
        end else begin
          orig = rnd128();
          st_in[u] = orig;
          m = 1'b0;
          expv = model(orig, 1'b0);
        end
        mode_in[u] = m;
        in_valid[u] = 1'b1;
        chk("rt_rdy", 128'(in_ready[u]), 128'd1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[u] = 1'b0;
  endtask

  localparam logic [127:0] PLAIN =
    128'hdb135345_f20a225c_d4d4d4d5_c6c6c6c6;
  localparam logic [127:0] MIXED =
    128'h8e4da1bc_9fdc589d_d5d5d7d6_c6c6c6c6;

  initial begin
    logic [127:0] a, b;
    int n;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      mode_in[u] = 1'b0;
      st_in[u] = '0;
      out_ready[u] = 1'b1;
    end
    #12;
    for (int u = 0; u < 3; u++) begin
      chk("rst_rdy", 128'(in_ready[u]), 128'd1);
      chk("rst_vld", 128'(out_valid[u]), 128'd0);
      chk("rst_st", st_out[u], '0);
    end
    @(negedge clk);
    nreset = 1'b1;

    run_block(0, PLAIN, 1'b0, 1'b0, MIXED, "fwd_vec");
    for (int u = 0; u < 3; u++)
      run_block(u, MIXED, 1'b1, 1'b0, PLAIN, "inv_vec");
    for (int u = 0; u < 3; u++) begin
      a = rnd128();
      run_block(u, a, 1'b0, 1'b1, model(a, 1'b0), "iso_fwd");
      a = rnd128();
      run_block(u, a, 1'b1, 1'b1, model(a, 1'b1), "iso_inv");
    end

    for (int u = 0; u < 3; u++) stream(u, 2000);

    // Backpressure on the one-column instance.
    a = rnd128();
    b = rnd128();
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    st_in[0] = a;
    mode_in[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 16) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp_lat", 128'(n), 128'd4);
    in_valid[0] = 1'b1;
    st_in[0] = b;
    mode_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_vld", 128'(out_valid[0]), 128'd1);
      chk("bp_rdy", 128'(in_ready[0]), 128'd0);
      chk("bp_st", st_out[0], model(a, 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_rel_rdy", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_hs_vld", 128'(out_valid[0]), 128'd0);
    chk("bp_hs_rdy", 128'(in_ready[0]), 128'd0);
    n = 0;
    while (!out_valid[0] && n < 16) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp_b_lat", 128'(n), 128'd4);
    chk("bp_b_st", st_out[0], model(b, 1'b1));
    @(posedge clk);
    @(negedge clk);

    // Reset after two columns of a block.
    in_valid[0] = 1'b1;
    st_in[0] = rnd128();
    mode_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mid_rst_rdy", 128'(in_ready[0]), 128'd1);
    chk("mid_rst_vld", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_st", st_out[0], '0);
    @(negedge clk);
    nreset = 1'b1;
    run_block(0, {4{32'h01010101}}, 1'b0, 1'b0,
              {4{32'h01010101}}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
